// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: host-to-device PS/2 command transmitter with device ACK check.
// Latency: INHIBIT_CYC+1 cycles to start bit, then device-paced; pad response <=4 cycles after a device clock edge.
// Backpressure: tx_ready only in IDLE; tx_valid outside IDLE is ignored, tx_data latched once at accept.
module ps2_host_tx #(
   parameter int CLK_HZ      = 100000000,
   parameter int INHIBIT_CYC = 10000,
   parameter int TIMEOUT_CYC = 1500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int INH_W = $clog2(INHIBIT_CYC) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_REQ       = 3'd2;
   localparam logic [2:0] S_SHIFT     = 3'd3;
   localparam logic [2:0] S_ACK       = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   // Reject parameter sets that cannot produce a sane bus sequence.
   generate
      if (CLK_HZ < 1 || INHIBIT_CYC < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
         $error("ps2_host_tx: invalid parameters");
      end
   endgenerate

   logic [1:0]       clk_sync_q, data_sync_q;
   logic             clk_prev_q;
   logic [2:0]       state_q, state_d;
   logic [7:0]       data_q, data_d;
   logic             par_q, par_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [3:0]       edge_cnt_q, edge_cnt_d;
   logic             ack_ok_q, ack_ok_d;
   logic             idle_seen_q, idle_seen_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic clk_s, data_s, clk_fall;
   assign clk_s    = clk_sync_q[1];
   assign data_s   = data_sync_q[1];
   assign clk_fall = clk_prev_q & ~clk_s;

   // Two-stage synchronisers plus one delayed copy of the clock for edge detection; idle-high reset avoids a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
         data_sync_q <= {data_sync_q[0], ps2_data_in};
         clk_prev_q  <= clk_s;
      end
   end

   // State and datapath registers; reset releases both pads immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         data_q      <= 8'h00;
         par_q       <= 1'b0;
         inh_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         edge_cnt_q  <= 4'd0;
         ack_ok_q    <= 1'b0;
         idle_seen_q <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         par_q       <= par_d;
         inh_cnt_q   <= inh_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         edge_cnt_q  <= edge_cnt_d;
         ack_ok_q    <= ack_ok_d;
         idle_seen_q <= idle_seen_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Transfer sequencing: inhibit, request-to-send, device-clocked shift, ACK sample, wait for bus idle.
   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      par_d       = par_q;
      inh_cnt_d   = inh_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      edge_cnt_d  = edge_cnt_q;
      ack_ok_d    = ack_ok_q;
      idle_seen_d = idle_seen_q;
      clk_oe_d    = clk_oe_q;
      data_oe_d   = data_oe_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               data_d    = tx_data;
               par_d     = ~^tx_data;
               inh_cnt_d = '0;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
               state_d   = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt_q == INH_W'(INHIBIT_CYC - 1)) begin
               // Start bit goes down as the clock is released.
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               tmo_cnt_d = '0;
               state_d   = S_REQ;
            end else begin
               inh_cnt_d = inh_cnt_q + INH_W'(1);
            end
         end
         S_REQ: begin
            edge_cnt_d = 4'd0;
            tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
            state_d    = S_SHIFT;
         end
         S_SHIFT, S_ACK: begin
            if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
               if (clk_fall && state_q == S_SHIFT) begin
                  // edge_cnt_q is the number of edges before this one, i.e. the bit index now presented.
                  edge_cnt_d = edge_cnt_q + 4'd1;
                  if (edge_cnt_q < 4'd8) begin
                     data_oe_d = ~data_q[edge_cnt_q[2:0]];
                  end else if (edge_cnt_q == 4'd8) begin
                     data_oe_d = ~par_q;
                  end else begin
                     data_oe_d = 1'b0;
                     state_d   = S_ACK;
                  end
               end else if (clk_fall) begin
                  ack_ok_d    = ~data_s;
                  idle_seen_d = 1'b0;
                  state_d     = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (clk_s && data_s) begin
               if (idle_seen_q) begin
                  done_d  = ack_ok_q;
                  err_d   = ~ack_ok_q;
                  state_d = S_IDLE;
               end else begin
                  idle_seen_d = 1'b1;
               end
            end else begin
               idle_seen_d = 1'b0;
            end
         end
         default: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   assign tx_ready    = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = done_q;
   assign tx_err      = err_q;

endmodule
